// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: pops via rd_en/rdata/empty and re-presents
// the words as a valid/ready stream through a 2-entry buffer that hides the read latency.
module fifo_rd_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic [CNT_WIDTH-1:0] pop_count_o
);

    logic [1:0]           occ_q, occ_d, occ_left;
    logic                 inflight_q;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     entry0_q, entry0_d, entry1_q, entry1_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop, rd_en;
    logic [2:0]           pending;

    always_comb begin
        pop     = valid_q & m_ready_i;
        pending = {1'b0, occ_q} + {2'b00, inflight_q};
        // (occ + inflight - pop) < 2 rewritten as occ + inflight < 2 + pop: no underflow
        rd_en   = rst_n_i & ~fifo_empty_i & ~flush_i & (pending < (pop ? 3'd3 : 3'd2));

        // valid_q mirrors occ_q != 0, so a pop implies occ_q >= 1
        occ_left = occ_q - {1'b0, pop};
        entry0_d = pop ? entry1_q : entry0_q;
        entry1_d = entry1_q;
        occ_d    = occ_left;
        cnt_d    = cnt_q + CNT_WIDTH'(pop);

        if (flush_i) begin
            occ_d    = 2'd0;
            entry0_d = entry0_q;
        end else if (inflight_q) begin
            if (occ_left == 2'd0) begin
                entry0_d = fifo_rdata_i;
            end else begin
                entry1_d = fifo_rdata_i;
            end
            occ_d = occ_left + 2'd1;
        end

        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            entry0_q   <= '0;
            entry1_q   <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            valid_q    <= valid_d;
            entry0_q   <= entry0_d;
            entry1_q   <= entry1_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = valid_q;
    assign m_data_o     = entry0_q;
    assign pop_count_o  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO in front, scoreboard on the stream side,
// plus a 4-bit-counter instance sharing the same inputs to exercise counter wrap.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n, flush, m_ready;
    logic        fifo_empty, rd_en, rd_en4;
    logic [7:0]  rdata, m_data, m_data4;
    logic        m_valid, m_valid4;
    logic [15:0] pop_count;
    logic [3:0]  cnt4;

    logic [7:0]  mem [256];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    int          rd_err = 0;
    int          rd_cnt = 0;
    logic [7:0]  sb [$];
    logic [7:0]  words [16];
    int          checks = 0;
    int          failures = 0;
    int          n, rd_cnt0;
    logic [7:0]  first;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_en), .fifo_rdata_i(rdata), .m_valid_o(m_valid), .m_data_o(m_data),
        .m_ready_i(m_ready), .pop_count_o(pop_count)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_en4), .fifo_rdata_i(rdata), .m_valid_o(m_valid4), .m_data_o(m_data4),
        .m_ready_i(m_ready), .pop_count_o(cnt4)
    );

    assign fifo_empty = (wp == rp);

    // Registered-read FIFO model; a read while empty is logged as an error
    always @(posedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            if (wp == rp) begin
                rd_err++;
            end else begin
                rdata <= mem[rp];
                rp    <= rp + 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp      = wp + 8'd1;
        sb.push_back(d);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("stream_data", {24'd0, m_data}, {24'd0, sb[0]});
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; m_ready = 1'b0; rdata = 8'd0;
        #1 rst_n = 1'b0;
        push(8'hA5);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        check("rst_count", {16'd0, pop_count}, 32'd0);
        rst_n = 1'b1;
        #1 check("rel_rd_en", {31'd0, rd_en}, 32'd1);
        m_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
        check("first_latency", n, 32'd3);

        // Streaming: 16 words, ready held high
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        n = 0;
        while (sb.size() > 0 && n < 60) begin @(posedge clk); #1; n++; end
        check("stream_cycles", n, 32'd18);
        check("stream_count", {16'd0, pop_count}, 32'd17);
        check("cnt4_wrap", {28'd0, cnt4}, 32'd1);
        check("stream_idle_valid", {31'd0, m_valid}, 32'd0);
        check("stream_idle_rd_en", {31'd0, rd_en}, 32'd0);

        // Backpressure
        m_ready = 1'b0;
        rd_cnt0 = rd_cnt;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        first = sb[0];
        repeat (6) @(posedge clk);
        #1;
        check("bp_reads", rd_cnt - rd_cnt0, 32'd2);
        check("bp_rd_en", {31'd0, rd_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
            check("bp_hold_data", {24'd0, m_data}, {24'd0, first});
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 60) begin @(posedge clk); #1; n++; end
        check("bp_drain_cycles", n, 32'd16);
        check("bp_count", {16'd0, pop_count}, 32'd33);

        // Random ready
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        check("rand_drained", sb.size(), 32'd0);
        check("rand_count", {16'd0, pop_count}, 32'd49);
        check("rand_rd_err", rd_err, 32'd0);

        // Flush with one word buffered and one in flight
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            push(words[i]);
        end
        repeat (4) @(posedge clk);
        #1;
        check("full_no_read", {31'd0, rd_en}, 32'd0);
        check("full_head", {24'd0, m_data}, {24'd0, words[0]});
        m_ready = 1'b1;
        #1 check("pop_read", {31'd0, rd_en}, 32'd1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        flush   = 1'b1;
        #1 check("flush_rd_en", {31'd0, rd_en}, 32'd0);
        check("preflush_data", {24'd0, m_data}, {24'd0, words[1]});
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", {31'd0, m_valid}, 32'd0);
        check("flush_count", {16'd0, pop_count}, 32'd50);
        #1 check("resume_rd_en", {31'd0, rd_en}, 32'd1);
        void'(sb.pop_front());
        void'(sb.pop_front());
        n = 0;
        while (!m_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("post_flush_head", {24'd0, m_data}, {24'd0, words[3]});
        m_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 60) begin @(posedge clk); #1; n++; end
        check("flush_drained", sb.size(), 32'd0);
        check("final_count", {16'd0, pop_count}, 32'd63);
        check("final_cnt4", {28'd0, cnt4}, 32'd15);
        check("final_rd_err", rd_err, 32'd0);

        // Mid-operation reset clears state at once
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_count", {16'd0, pop_count}, 32'd0);
        check("midrst_rd_en", {31'd0, rd_en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
